// File: rtl/dmem_map_pkg.sv
// Address map, region select and console status layout for the data-memory responder.
package dmem_map_pkg;

    localparam logic [31:0] OFF_CONSOLE = 32'h0000_0000;
    localparam logic [31:0] OFF_CYCLE   = 32'h0000_0004;
    localparam logic [31:0] OFF_TOHOST  = 32'h0000_0008;
    localparam logic [31:0] OFF_ERRCNT  = 32'h0000_000C;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_CONSOLE,
        REG_CYCLE,
        REG_TOHOST,
        REG_ERRCNT,
        REG_NONE
    } region_e;

    localparam int CON_COUNT_LSB = 0;
    localparam int CON_COUNT_W   = 8;
    localparam int CON_FULL_BIT  = 8;
    localparam int CON_DROP_LSB  = 16;
    localparam int CON_DROP_W    = 16;

    function automatic logic [31:0] console_status(input logic [15:0] drop_cnt,
                                                   input logic        full,
                                                   input logic [7:0]  count);
        logic [31:0] st;
        st = '0;
        st[CON_COUNT_LSB +: CON_COUNT_W] = count;
        st[CON_FULL_BIT]                 = full;
        st[CON_DROP_LSB +: CON_DROP_W]   = drop_cnt;
        return st;
    endfunction

endpackage

// File: rtl/dmem_mmio_responder_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a pop while full lets a same-cycle push through.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // NOTE: storage is deliberately not reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // NOTE: non-blocking updates so both pointers advance from their pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-memory bus responder: word RAM plus console FIFO, cycle counter and TOHOST register.
// Define DMEM_BUS_ERR_EN to build the unmapped-access pulse and its error counter at +0xC.
module dmem_mmio_responder
    import dmem_map_pkg::*;
#(
    parameter int          RAM_WORDS  = 1024,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wen,
    input  logic        ren,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        done,
    output logic [31:0] tohost,
    output logic        bus_err
);

    localparam int          RAM_AW    = $clog2(RAM_WORDS);
    localparam int          FIFO_CW   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

    region_e              region;
    logic [31:0]          mmio_off;
    logic [RAM_AW-1:0]    ram_idx;
    logic [31:0]          ram [RAM_WORDS];
    logic [31:0]          rd_val;
    logic [31:0]          cycle_cnt;
    logic [15:0]          drop_cnt;
    logic                 con_push;
    logic                 con_drop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [FIFO_CW-1:0]   fifo_count;
`ifdef DMEM_BUS_ERR_EN
    logic [15:0]          err_cnt;
    logic                 unmapped;
`endif

    assign ram_idx = addr[RAM_AW+1:2];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        mmio_off = (addr - MMIO_BASE) & ~32'h3;
        region   = REG_NONE;
        if (addr < RAM_BYTES) begin
            region = REG_RAM;
        end else begin
            case (mmio_off)
                OFF_CONSOLE: region = REG_CONSOLE;
                OFF_CYCLE:   region = REG_CYCLE;
                OFF_TOHOST:  region = REG_TOHOST;
`ifdef DMEM_BUS_ERR_EN
                OFF_ERRCNT:  region = REG_ERRCNT;
`endif
                default:     region = REG_NONE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wen && region == REG_RAM) begin
            ram[ram_idx] <= wdata;
        end
    end

    // All sources are sampled before this edge's writes/increments, giving read-before-write.
    always_comb begin
        rd_val = '0;
        case (region)
            REG_RAM:     rd_val = ram[ram_idx];
            REG_CONSOLE: rd_val = console_status(drop_cnt, fifo_full, 8'(fifo_count));
            REG_CYCLE:   rd_val = cycle_cnt;
            REG_TOHOST:  rd_val = tohost;
`ifdef DMEM_BUS_ERR_EN
            REG_ERRCNT:  rd_val = {16'h0000, err_cnt};
`endif
            default:     rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata     <= '0;
            cycle_cnt <= '0;
            done      <= 1'b0;
            tohost    <= '0;
            drop_cnt  <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (ren) begin
                rdata <= rd_val;
            end
            if (wen && region == REG_TOHOST) begin
                tohost <= wdata;
                done   <= 1'b1;
            end
            if (con_drop && drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    // A push into a full FIFO survives only when the sink drains the head in the same cycle.
    assign con_push = wen && region == REG_CONSOLE;
    assign con_drop = con_push && fifo_full && !tx_ready;
    assign tx_valid = !fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (con_push),
        .pop   (tx_ready),
        .din   (wdata[7:0]),
        .dout  (tx_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef DMEM_BUS_ERR_EN
    assign unmapped = (wen || ren) && region == REG_NONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_err <= 1'b0;
            err_cnt <= '0;
        end else begin
            bus_err <= unmapped;
            if (unmapped && err_cnt != 16'hFFFF) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end
`else
    assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Self-checking bench for dmem_mmio_responder: directed scenarios then random bus traffic vs a cycle model.
module tb_dmem_mmio_responder;

    localparam int          RAM_WORDS  = 1024;
    localparam int          FIFO_DEPTH = 8;
    localparam logic [31:0] MMIO_BASE  = 32'h1000_0000;
    localparam logic [31:0] RAM_BYTES  = RAM_WORDS * 4;
    localparam logic [31:0] A_CON      = MMIO_BASE + 32'h0;
    localparam logic [31:0] A_CYC      = MMIO_BASE + 32'h4;
    localparam logic [31:0] A_TOH      = MMIO_BASE + 32'h8;
    localparam logic [31:0] A_ERR      = MMIO_BASE + 32'hC;
`ifdef DMEM_BUS_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        wen;
    logic        ren;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        done;
    logic [31:0] tohost;
    logic        bus_err;

    dmem_mmio_responder #(
        .RAM_WORDS  (RAM_WORDS),
        .FIFO_DEPTH (FIFO_DEPTH),
        .MMIO_BASE  (MMIO_BASE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wen      (wen),
        .ren      (ren),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .done     (done),
        .tohost   (tohost),
        .bus_err  (bus_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state, advanced once per bus cycle
    logic [31:0] m_ram [int];
    logic [7:0]  m_q [$];
    logic [31:0] m_cycle;
    logic [31:0] m_tohost;
    logic [31:0] m_rdata;
    logic        m_done;
    logic        m_bus_err;
    logic [15:0] m_drop;
    logic [15:0] m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // 0 ram, 1 console, 2 cycle, 3 tohost, 4 errcnt, 5 unmapped
    function automatic int kind_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - MMIO_BASE;
        if (a < RAM_BYTES)          return 0;
        if (off < 4)                return 1;
        if (off < 8)                return 2;
        if (off < 12)               return 3;
        if (ERR_EN && off < 16)     return 4;
        return 5;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] cnt;
        cnt = m_q.size();
        case (kind_of(a))
            0:       return m_ram[int'(a / 4)];
            1:       return {m_drop, 7'b0, (m_q.size() == FIFO_DEPTH), cnt[7:0]};
            2:       return m_cycle;
            3:       return m_tohost;
            4:       return {16'h0, m_err};
            default: return 32'h0;
        endcase
    endfunction

    // One bus cycle: drive, check stream outputs, advance model, clock, check registered outputs
    task automatic bus(input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] d, input logic rdy);
        bit pre_full;
        bit do_pop;
        int k;
        wen = w; ren = r; addr = a; wdata = d; tx_ready = rdy;
        #1;
        check("tx_valid", tx_valid, m_q.size() > 0);
        if (m_q.size() > 0) check("tx_data", tx_data, m_q[0]);
        k = kind_of(a);
        if (r) m_rdata = model_read(a);
        pre_full = (m_q.size() == FIFO_DEPTH);
        do_pop   = rdy && m_q.size() > 0;
        if (do_pop) void'(m_q.pop_front());
        if (w) begin
            if (k == 0) m_ram[int'(a / 4)] = d;
            if (k == 1) begin
                if (!pre_full || do_pop) m_q.push_back(d[7:0]);
                else if (m_drop != 16'hFFFF) m_drop++;
            end
            if (k == 3) begin
                m_tohost = d;
                m_done   = 1'b1;
            end
        end
        m_bus_err = ERR_EN && (w || r) && k == 5;
        if (m_bus_err && m_err != 16'hFFFF) m_err++;
        m_cycle++;
        @(posedge clk);
        #1;
        wen = 1'b0; ren = 1'b0;
        check("rdata", rdata, m_rdata);
        check("done", done, m_done);
        check("tohost", tohost, m_tohost);
        check("bus_err", bus_err, m_bus_err);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus(1'b1, 1'b0, a, d, 1'b0);
    endtask

    task automatic rd(input logic [31:0] a);
        bus(1'b0, 1'b1, a, 32'h0, 1'b0);
    endtask

    task automatic idle(input logic rdy);
        bus(1'b0, 1'b0, 32'h0, 32'h0, rdy);
    endtask

    task automatic do_reset();
        rst = 1'b1; wen = 1'b0; ren = 1'b0; tx_ready = 1'b0; addr = '0; wdata = '0;
        @(posedge clk);
        #1;
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_rdata", rdata, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_q.delete();
        m_cycle = 0; m_tohost = 0; m_rdata = 0; m_done = 0;
        m_bus_err = 0; m_drop = 0; m_err = 0;
        check("rst_done", done, 1'b0);
        check("rst_tohost", tohost, 32'h0);
        check("rst_bus_err", bus_err, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        do_reset();

        // RAM write then read, and ignored low address bits
        wr(32'h40, 32'hDEAD_BEEF);
        rd(32'h40);
        check("ram_rd_40", rdata, 32'hDEAD_BEEF);
        wr(32'h44, 32'hCAFE_F00D);
        rd(32'h47);
        check("ram_rd_47", rdata, 32'hCAFE_F00D);

        // Simultaneous write and read returns the old word
        wr(32'h10, 32'h0000_1111);
        bus(1'b1, 1'b1, 32'h10, 32'h0000_2222, 1'b0);
        check("rbw_old", rdata, 32'h0000_1111);
        rd(32'h10);
        check("rbw_new", rdata, 32'h0000_2222);

        // Console overflow with the sink stalled
        for (int i = 0; i < 10; i++) wr(A_CON, 32'h41 + i);
        rd(A_CON);
        check("con_status_ovf", rdata, 32'h0002_0108);
        for (int i = 0; i < 8; i++) begin
            check("drain_order", tx_data, 8'h41 + i);
            idle(1'b1);
        end
        check("drain_empty", tx_valid, 1'b0);

        // Push and pop together while full
        for (int i = 0; i < 8; i++) wr(A_CON, 32'h41 + i);
        bus(1'b1, 1'b0, A_CON, 32'h5A, 1'b1);
        rd(A_CON);
        check("con_status_pp", rdata, 32'h0002_0108);
        check("head_after_pp", tx_data, 8'h42);
        for (int i = 0; i < 7; i++) idle(1'b1);
        check("last_is_z", tx_data, 8'h5A);
        idle(1'b1);

        // Reset mid-operation, then cycle counter timing
        wr(A_CON, 32'h31);
        wr(A_CON, 32'h32);
        rd(32'h40);
        do_reset();
        for (int i = 0; i < 20; i++) idle(1'b0);
        rd(A_CYC);
        check("cycle_20", rdata, 32'd20);

        // TOHOST and sticky done, cleared only by reset
        wr(A_TOH, 32'h1);
        check("done_set", done, 1'b1);
        check("tohost_1", tohost, 32'h1);
        wr(A_TOH, 32'h5);
        check("tohost_5", tohost, 32'h5);
        do_reset();
        rd(A_CYC);
        check("cycle_after_rst", rdata, 32'h0);

        // Unmapped access and the optional error counter
        rd(32'h2000_0000);
        check("unmapped_rd", rdata, 32'h0);
        check("bus_err_pulse", bus_err, ERR_EN);
        idle(1'b0);
        check("bus_err_clear", bus_err, 1'b0);
        rd(A_ERR);
        check("err_cnt", rdata, {31'h0, ERR_EN});

        // Random traffic over a small RAM window and every MMIO register
        for (int i = 0; i < 16; i++) wr(i * 4, $urandom);
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            case ($urandom_range(0, 9))
                0, 1, 2, 3: a = $urandom_range(0, 15) * 4 + $urandom_range(0, 3);
                4, 5:       a = A_CON;
                6:          a = A_CYC;
                7:          a = A_TOH;
                8:          a = A_ERR;
                default: begin
                    case ($urandom_range(0, 2))
                        0:       a = 32'h2000_0000;
                        1:       a = MMIO_BASE + 32'h10;
                        default: a = RAM_BYTES;
                    endcase
                end
            endcase
            bus(1'($urandom), 1'($urandom), a, $urandom, 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
- Responder on the core's data-memory bus (wen/ren/addr/wdata/rdata): the target the pipeline's MEM stage drives.
- Replaces the bare RAM with a word-addressed synchronous RAM plus a small MMIO region.
- MMIO region holds a console TX FIFO drained over a valid/ready stream, a free-running cycle counter and a TOHOST completion register.
- Gives programs console output and a test-end signal with no bench-side memory peeking.

Parameters:
- RAM_WORDS, 1024, RAM depth in 32-bit words; power of two.
- FIFO_DEPTH, 8, console TX FIFO entries; power of two, ≥2.
- MMIO_BASE, 32'h1000_0000, base address of the MMIO window.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- wen  in  1  bus write strobe, one access per cycle
- ren  in  1  bus read strobe
- addr  in  32  byte address; addr[1:0] ignored (word access only)
- wdata  in  32  write data
- rdata  out  32  read data, registered
- tx_valid  out  1  console byte available
- tx_ready  in  1  sink accepts byte
- tx_data  out  8  console byte (FIFO head)
- done  out  1  sticky; set by a TOHOST write
- tohost  out  32  last value written to TOHOST
- bus_err  out  1  unmapped-access pulse (only with DMEM_BUS_ERR_EN)

Behaviour:
- Reset: rst, synchronous, active-high; clock clk. On reset:
  - rdata=0, done=0, tohost=0, tx_valid=0, bus_err=0.
  - FIFO empty, cycle counter=0, drop counter=0.
  - RAM contents not cleared.
- Decode:
  - RAM: addr < RAM_WORDS*4; index addr[log2(RAM_WORDS)+1:2].
  - MMIO (offset from MMIO_BASE):
    - +0x0 CONSOLE. Write pushes wdata[7:0]. Read returns {drop_cnt[15:0], 7'b0, full, count[7:0]}.
    - +0x4 CYCLE. Read returns counter. Write ignored.
    - +0x8 TOHOST. Write latches wdata into tohost and sets done. Read returns tohost.
  - Anything else: unmapped. Read returns 0, write ignored.
- Read latency: exactly 1 cycle. rdata is updated at the edge where ren=1 and holds until the next ren.
- wen and ren in the same cycle:
  - Write is performed.
  - rdata returns the pre-write value (read-before-write), for RAM and for MMIO.
- Cycle counter:
  - Increments every non-reset cycle, 32-bit wrap 0xFFFF_FFFF→0.
  - A read returns the value before that edge's increment.
- Console FIFO:
  - Pointers are log2(FIFO_DEPTH)+1 bits wide. Full/empty come from the MSB compare.
  - tx_valid = !empty; tx_data = head entry, combinational from storage.
  - Pop when tx_valid && tx_ready.
  - Push while full is dropped, and drop_cnt increments (saturates at 0xFFFF).
  - Push and pop in the same cycle while full: both succeed, count unchanged, no drop.
  - Push and pop in the same cycle while empty: push only (tx_valid was 0).
- done is sticky until rst. Further TOHOST writes update tohost; done stays 1.
- Reset mid-operation: FIFO contents discarded, tx_valid drops the cycle after rst; in-flight read data discarded.

Optional Feature:
- Macro DMEM_BUS_ERR_EN.
- Defined:
  - bus_err pulses 1 cycle, aligned with rdata timing, for any wen/ren to an unmapped address.
  - A 16-bit saturating err_cnt is readable at MMIO +0xC.
- Undefined:
  - bus_err is tied 0.
  - +0xC is unmapped (reads 0).
  - No counter logic is built.

Decomposition:
- Package dmem_map_pkg:
  - MMIO offsets: OFF_CONSOLE=0x0, OFF_CYCLE=0x4, OFF_TOHOST=0x8, OFF_ERRCNT=0xC.
  - Region-select enum {REG_RAM, REG_CONSOLE, REG_CYCLE, REG_TOHOST, REG_ERRCNT, REG_NONE}.
  - Console status field positions.
- Sub-module sync_fifo:
  - Parameters WIDTH and DEPTH.
  - Ports push/pop/din/dout/full/empty/count.
  - Reused later for the instruction-side path.

Test Plan:
- RAM: write 0xDEADBEEF to 0x40; next cycle ren 0x40 → rdata=0xDEADBEEF one cycle later. Read 0x44 with addr[1:0]=2'b11 → data stored at word 0x44.
- Simultaneous access: word 0x10 holds 0x1111. wen+ren to 0x10 with wdata=0x2222 → rdata=0x1111. Following read → 0x2222.
- Console overflow, tx_ready=0: push 'A'..'J' (10 bytes) → FIFO holds 'A'..'H'; CONSOLE read → count=8, full=1, drop_cnt=2. Raise tx_ready → 'A'..'H' emitted in order, then tx_valid=0.
- Full-boundary push+pop: FIFO full, tx_ready=1 and push 'Z' in the same cycle → 'A' popped, 'Z' accepted, count stays 8, drop_cnt unchanged.
- Cycle and TOHOST:
  - 20 cycles after reset, read CYCLE → value 19 or 20 per the edge rule, checked exactly.
  - Write 1 to TOHOST → done=1, tohost=1 next cycle.
  - rst → done=0, cycle=0.
- DMEM_BUS_ERR_EN: read 0x2000_0000 → rdata=0, bus_err one 1-cycle pulse, err_cnt=1. Without the macro → bus_err stays 0.
